// File: rtl/instr_fetch_decode.sv
// instr_fetch_decode: fetches 16-bit instructions from program memory and
// decodes each one into a single execute cycle of register-file/ALU controls.
// Handshake: mem_rd is raised in FETCH and held, with mem_addr stable, until a
// cycle in which mem_valid is high; that cycle transfers mem_rdata into IR.
// mem_valid is ignored in every cycle where mem_rd is low.
module instr_fetch_decode #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_valid,
    input  logic [15:0]       mem_rdata,
    output logic [15:0]       RegEnable,
    output logic [3:0]        MuxControlA,
    output logic [3:0]        MuxControlB,
    output logic              MuxControlC,
    output logic [15:0]       AluControl,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_HALT    = 3'd4
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [15:0]         r_ir;
    logic                r_mem_rd;
    logic                r_halted;

    logic [3:0]          w_op;
    logic [3:0]          w_rd;
    logic [3:0]          w_ext;
    logic [3:0]          w_rs;
    logic                w_is_nop;
    logic                w_is_halt;
    logic                w_is_reg;

    assign w_op      = r_ir[15:12];
    assign w_rd      = r_ir[11:8];
    assign w_ext     = r_ir[7:4];
    assign w_rs      = r_ir[3:0];
    assign w_is_nop  = (w_op == 4'h0) && (w_ext == 4'h0);
    assign w_is_halt = (w_op == 4'hF);
    assign w_is_reg  = (w_op == 4'h0) && (w_ext != 4'h0);

    // Control FSM: sequences fetch/decode/execute and owns pc, IR, mem_rd, halted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_pc     <= '0;
            r_ir     <= '0;
            r_mem_rd <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (run) begin
                        r_state  <= S_FETCH;
                        r_mem_rd <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (mem_valid) begin
                        r_ir     <= mem_rdata;
                        r_mem_rd <= 1'b0;
                        r_state  <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_state <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    // pc naturally wraps at 2**ADDR_W.
                    r_pc <= r_pc + ADDR_W'(1);
                    if (w_is_halt) begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                    end else if (run) begin
                        r_state  <= S_FETCH;
                        r_mem_rd <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_mem_rd <= 1'b0;
                end
            endcase
        end
    end

    // Decode of the held IR; write enable only pulses in EXECUTE, never for r0.
    always_comb begin
        MuxControlA = w_rd;
        MuxControlB = 4'h0;
        MuxControlC = 1'b0;
        RegEnable   = 16'h0000;
        if (w_is_reg) begin
            MuxControlB = w_rs;
        end else if (w_is_nop) begin
            MuxControlB = w_rs;
        end else if (!w_is_halt) begin
            MuxControlC = 1'b1;
        end
        if ((r_state == S_EXECUTE) && !w_is_nop && !w_is_halt && (w_rd != 4'h0)) begin
            RegEnable = 16'(1) << w_rd;
        end
    end

    assign AluControl = r_ir;
    assign mem_rd     = r_mem_rd;
    assign mem_addr   = r_pc;
    assign pc         = r_pc;
    assign halted     = r_halted;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Bench for instr_fetch_decode: a program-memory responder with per-address
// wait states pushes the expected execute-cycle controls into exp_q; a monitor
// pops and compares on every EXECUTE cycle. A second instance with ADDR_W=2
// covers pc wrap.
module tb_instr_fetch_decode;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_FETCH   = 3'd1;
    localparam logic [2:0] ST_DECODE  = 3'd2;
    localparam logic [2:0] ST_EXECUTE = 3'd3;
    localparam logic [2:0] ST_HALT    = 3'd4;
    localparam int W = 58;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        run;
    logic        mem_rd;
    logic [7:0]  mem_addr;
    logic        mem_valid;
    logic [15:0] mem_rdata;
    logic [15:0] reg_en;
    logic [3:0]  mux_a;
    logic [3:0]  mux_b;
    logic        mux_c;
    logic [15:0] alu_ctl;
    logic [7:0]  pc;
    logic        halted;
    logic [2:0]  dbg_state;

    logic        run2;
    logic        mem_rd2;
    logic [1:0]  mem_addr2;
    logic        mem_valid2;
    logic [15:0] mem_rdata2;
    logic [15:0] reg_en2;
    logic [3:0]  mux_a2;
    logic [3:0]  mux_b2;
    logic        mux_c2;
    logic [15:0] alu_ctl2;
    logic [1:0]  pc2;
    logic        halted2;
    logic [2:0]  dbg_state2;

    instr_fetch_decode #(.ADDR_W(8)) dut (
        .clk(clk), .reset(reset), .run(run), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_valid(mem_valid), .mem_rdata(mem_rdata), .RegEnable(reg_en),
        .MuxControlA(mux_a), .MuxControlB(mux_b), .MuxControlC(mux_c),
        .AluControl(alu_ctl), .pc(pc), .halted(halted), .dbg_state(dbg_state)
    );

    instr_fetch_decode #(.ADDR_W(2)) dut2 (
        .clk(clk), .reset(reset), .run(run2), .mem_rd(mem_rd2), .mem_addr(mem_addr2),
        .mem_valid(mem_valid2), .mem_rdata(mem_rdata2), .RegEnable(reg_en2),
        .MuxControlA(mux_a2), .MuxControlB(mux_b2), .MuxControlC(mux_c2),
        .AluControl(alu_ctl2), .pc(pc2), .halted(halted2), .dbg_state(dbg_state2)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    logic [15:0]  prog[256];
    int           waits[256];
    int           n_checks = 0;
    int           n_errors = 0;
    int           n_exec = 0;
    int           cyc = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Expected execute-cycle item: {chk_abc, RegEnable, A, B, C, Alu, pc_after, latency}
    function automatic logic [W-1:0] model(input logic [15:0] w, input logic [7:0] addr, input int wt);
        logic [3:0]  op, rd, ext, rs;
        logic [15:0] re;
        logic [3:0]  a, b;
        logic        c, abc;
        logic [7:0]  lat;
        op = w[15:12]; rd = w[11:8]; ext = w[7:4]; rs = w[3:0];
        re = 16'h0; a = rd; b = 4'h0; c = 1'b0; abc = 1'b1;
        if (op == 4'hF || (op == 4'h0 && ext == 4'h0)) begin
            abc = 1'b0;
        end else begin
            if (rd != 4'h0) re = 16'h0001 << rd;
            if (op == 4'h0) begin b = rs; c = 1'b0; end
            else begin b = 4'h0; c = 1'b1; end
        end
        lat = 8'(3 + wt);
        return {abc, re, a, b, c, w, 8'(addr + 8'd1), lat};
    endfunction

    // ---------------- memory responder (driver) ----------------
    initial begin
        int wcnt;
        logic [7:0] fetch_addr;
        wcnt = 0;
        fetch_addr = 8'h0;
        mem_valid = 1'b0;
        mem_rdata = 16'h0;
        forever begin
            @(negedge clk);
            if (reset) begin
                mem_valid = 1'b0;
                wcnt = 0;
            end else if (mem_rd) begin
                if (wcnt == 0) fetch_addr = mem_addr;
                else chk("addr_stable", mem_addr, fetch_addr);
                if (wcnt >= waits[mem_addr]) begin
                    mem_valid = 1'b1;
                    mem_rdata = prog[mem_addr];
                    exp_q.push_back(model(prog[mem_addr], mem_addr, waits[mem_addr]));
                    wcnt = 0;
                end else begin
                    mem_valid = 1'b0;
                    mem_rdata = 16'($urandom);
                    wcnt++;
                end
            end else begin
                // Stray valids while no request is outstanding must be ignored.
                mem_valid = 1'($urandom_range(0, 1));
                mem_rdata = 16'($urandom);
                wcnt = 0;
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic [W-1:0] e;
        logic         prev_rd;
        logic         pc_pending;
        logic [7:0]   exp_pc;
        int           fetch_start;
        prev_rd = 1'b0; pc_pending = 1'b0; exp_pc = 8'h0; fetch_start = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                prev_rd = 1'b0;
                pc_pending = 1'b0;
            end else begin
                if (pc_pending) begin
                    chk("pc_after_exec", pc, exp_pc);
                    pc_pending = 1'b0;
                end
                if (mem_rd && !prev_rd) fetch_start = cyc;
                prev_rd = mem_rd;
                if (dbg_state == ST_EXECUTE) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_exec", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        n_exec++;
                        chk("reg_enable", reg_en, e[56:41]);
                        chk("alu_control", alu_ctl, e[31:16]);
                        if (e[57]) begin
                            chk("mux_a", mux_a, e[40:37]);
                            chk("mux_b", mux_b, e[36:33]);
                            chk("mux_c", mux_c, e[32]);
                        end
                        chk("latency", cyc - fetch_start + 1, e[7:0]);
                        exp_pc = e[15:8];
                        pc_pending = 1'b1;
                    end
                end
            end
        end
    end

    task automatic wait_state(input logic [2:0] st, input int max, input string tag);
        for (int i = 0; i < max && dbg_state !== st; i++) @(negedge clk);
        chk(tag, dbg_state, st);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [1:0] exp2;
        int k;
        reset = 1'b1;
        run = 1'b0;
        run2 = 1'b0;
        mem_valid2 = 1'b1;
        mem_rdata2 = 16'h2105;
        for (int i = 0; i < 256; i++) begin prog[i] = 16'hF000; waits[i] = 0; end
        prog[0] = 16'h0152; waits[0] = 0;
        prog[1] = 16'h0352; waits[1] = 2;
        prog[2] = 16'h0050; waits[2] = 0;
        prog[3] = 16'h0000; waits[3] = 1;
        prog[4] = 16'h1234; waits[4] = 0;
        prog[5] = 16'hF000; waits[5] = 0;

        repeat (2) @(negedge clk);
        chk("rst_state", dbg_state, ST_IDLE);
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_pc", pc, 0);
        chk("rst_halted", halted, 0);
        chk("rst_reg_en", reg_en, 0);
        chk("rst_alu", alu_ctl, 0);
        chk("rst_mux", {mux_a, mux_b, mux_c}, 0);

        // Instructions 0..3, then run dropped while addr 4 is in DECODE.
        reset = 1'b0;
        @(negedge clk);
        run = 1'b1;
        k = 0;
        while (k < 200 && !(dbg_state == ST_DECODE && pc == 8'd4)) begin
            @(negedge clk);
            k++;
        end
        chk("reach_decode_4", {dbg_state, pc}, {ST_DECODE, 8'd4});
        run = 1'b0;
        wait_state(ST_IDLE, 5, "idle_after_run_drop");
        chk("idle_pc", pc, 5);
        repeat (3) begin
            @(negedge clk);
            chk("idle_hold_state", dbg_state, ST_IDLE);
            chk("idle_no_rd", mem_rd, 0);
        end

        // Resume: fetch from pc 5, which is HALT.
        run = 1'b1;
        wait_state(ST_HALT, 20, "reach_halt");
        chk("halted", halted, 1);
        repeat (4) begin
            @(negedge clk);
            chk("halt_no_rd", mem_rd, 0);
            chk("halt_reg_en", reg_en, 0);
        end
        chk("exec_count", n_exec, 6);
        chk("exp_drained", exp_q.size(), 0);

        // pc wrap on the ADDR_W=2 instance.
        run2 = 1'b1;
        for (int j = 0; j < 4; j++) begin
            for (int i = 0; i < 10 && dbg_state2 !== ST_EXECUTE; i++) @(negedge clk);
            chk("w2_exec", dbg_state2, ST_EXECUTE);
            chk("w2_reg_en", reg_en2, 16'h0002);
            @(negedge clk);
            exp2 = 2'(j + 1);
            chk("w2_pc", pc2, exp2);
            chk("w2_mem_addr", mem_addr2, exp2);
            chk("w2_fetch", {dbg_state2, mem_rd2}, {ST_FETCH, 1'b1});
        end
        run2 = 1'b0;

        // Reset from HALT, then asynchronous reset in the middle of a stalled fetch.
        run = 1'b0;
        reset = 1'b1;
        #1;
        chk("halt_reset_async", halted, 0);
        @(negedge clk);
        reset = 1'b0;
        waits[1] = 200;
        run = 1'b1;
        wait_state(ST_EXECUTE, 10, "reexec_0");
        wait_state(ST_FETCH, 10, "refetch_1");
        repeat (3) @(negedge clk);
        chk("stall_pc", pc, 1);
        chk("stall_rd", mem_rd, 1);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("async_rst_mem_rd", mem_rd, 0);
        chk("async_rst_reg_en", reg_en, 0);
        chk("async_rst_pc", pc, 0);
        chk("async_rst_halted", halted, 0);
        chk("async_rst_state", dbg_state, ST_IDLE);
        run = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("final_exp_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Global time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
